hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage core. Decodes register dependencies, load-use hazards, taken branches, jumps, multi-cycle mult/div occupancy and data-memory wait. From these it drives the write, stall and flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It sits beside the datapath with no data path of its own, and is the only source of those control signals.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/hazard_detect.sv | 25 ++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control blocks (hazard_ctrl, hazard_detect).
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_HOLD = 1'b1
  } hc_state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_LAT_DEFAULT = 32;
  localparam int         PERF_CNT_W     = 32;
  localparam int         MD_CNT_W       = 8;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and mult/div hazard detection; x0 never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rs,
  input  logic       i_id_uses_rt,
  input  logic       i_id_md_use,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  input  logic       i_md_busy,
  output logic       o_load_use,
  output logic       o_md_hazard
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit    = i_id_uses_rs & (i_id_rs == i_ex_rd);
  assign w_rt_hit    = i_id_uses_rt & (i_id_rt == i_ex_rd);
  assign o_load_use  = i_ex_memread & (i_ex_rd != REG_ZERO) & (w_rs_hit | w_rt_hit);
  assign o_md_hazard = i_md_busy & i_id_md_use;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: freeze FSM, mult/div countdown and control priority mux.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush/freeze counters (and the CNT_W parameter).
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
`ifdef HAZARD_PERF_CNT_EN
  ,parameter int CNT_W = PERF_CNT_W
`endif
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_md_use,
  input  logic       id_jump,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       ex_md_start,
  input  logic       dmem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_write,
  output logic       idex_flush,
  output logic       exmem_write,
  output logic       md_busy,
  output logic       mem_hold
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [CNT_W-1:0] stall_cycles
  ,output logic [CNT_W-1:0] flush_events
  ,output logic [CNT_W-1:0] freeze_cycles
`endif
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT);

  hc_state_t           r_state;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic                r_rst_q;

  logic w_in_rst;
  logic w_freeze;
  logic w_load_use;
  logic w_md_hazard;
  logic w_stall_grant;

  // Reset outputs persist until the first posedge after rst falls.
  assign w_in_rst = rst | r_rst_q;
  assign w_freeze = ~dmem_ready;
  assign md_busy  = (r_md_cnt != '0);
  assign mem_hold = (r_state == MEM_HOLD);

  hazard_detect u_detect (
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_uses_rs (id_uses_rs),
    .i_id_uses_rt (id_uses_rt),
    .i_id_md_use  (id_md_use),
    .i_ex_memread (ex_memread),
    .i_ex_rd      (ex_rd),
    .i_md_busy    (md_busy),
    .o_load_use   (w_load_use),
    .o_md_hazard  (w_md_hazard)
  );

  assign w_stall_grant = ~w_in_rst & ~w_freeze & ~ex_branch_taken & (w_load_use | w_md_hazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_q  <= 1'b1;
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else if (r_rst_q) begin
      r_rst_q  <= 1'b0;
    end else begin
      case (r_state)
        RUN:      if (!dmem_ready) r_state <= MEM_HOLD;
        MEM_HOLD: if (dmem_ready)  r_state <= RUN;
        default:  r_state <= RUN;
      endcase
      // A new issue restarts the window even if the unit is still busy.
      if (ex_md_start && !w_freeze) r_md_cnt <= MD_LOAD;
      else if (r_md_cnt != '0)      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    if (w_in_rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (w_freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_load_use | w_md_hazard) begin
      pc_write   = 1'b0;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles  <= '0;
      flush_events  <= '0;
      freeze_cycles <= '0;
    end else begin
      if (w_stall_grant && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (ifid_flush && !w_in_rst && (flush_events != '1))
        flush_events <= flush_events + 1'b1;
      if (w_freeze && !w_in_rst && (freeze_cycles != '1))
        freeze_cycles <= freeze_cycles + 1'b1;
    end
  end
`else
  logic w_unused_grant;
  assign w_unused_grant = w_stall_grant;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, corner-case sequences and a randomized run vs a reference model.
module tb_hazard_ctrl;

  localparam int MD_LAT = 4;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mdu;
    logic       jmp;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       mds;
    logic       rdy;
    logic       rst;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_md_use, id_jump;
  logic       ex_memread, ex_branch_taken, ex_md_start, dmem_ready;
  logic       pc_write, ifid_write, ifid_stall, ifid_flush;
  logic       idex_write, idex_flush, exmem_write, md_busy, mem_hold;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, freeze_cycles;
`endif

  logic [6:0] w_out7;
  assign w_out7 = {pc_write, ifid_write, ifid_stall, ifid_flush, idex_write, idex_flush, exmem_write};

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  // Reference model state
  int m_md_rem = 0;
  bit m_hold   = 1'b0;
  bit m_rst_q  = 1'b1;

  hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_md_use       (id_md_use),
    .id_jump         (id_jump),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .ex_md_start     (ex_md_start),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_write      (idex_write),
    .idex_flush      (idex_flush),
    .exmem_write     (exmem_write),
    .md_busy         (md_busy),
    .mem_hold        (mem_hold)
`ifdef HAZARD_PERF_CNT_EN
    ,.stall_cycles   (stall_cycles)
    ,.flush_events   (flush_events)
    ,.freeze_cycles  (freeze_cycles)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic in_t mk(logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                             logic mdu, logic jmp, logic mr, logic [4:0] rd,
                             logic br, logic mds, logic rdy);
    in_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mdu = mdu; v.jmp = jmp;
    v.mr = mr; v.rd = rd; v.br = br; v.mds = mds; v.rdy = rdy; v.rst = 1'b0;
    return v;
  endfunction

  // Driver tasks
  task automatic set_in(in_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    id_md_use = v.mdu; id_jump = v.jmp; ex_memread = v.mr; ex_rd = v.rd;
    ex_branch_taken = v.br; ex_md_start = v.mds; dmem_ready = v.rdy; rst = v.rst;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: control outputs straight from the priority rules.
  function automatic logic [8:0] model_out(in_t v);
    bit in_rst, frz, lu, mdh;
    logic [6:0] o;
    in_rst = v.rst || m_rst_q;
    frz    = !v.rdy;
    lu     = v.mr && (v.rd != 0) && ((v.urs && v.rs == v.rd) || (v.urt && v.rt == v.rd));
    mdh    = (m_md_rem > 0) && v.mdu;
    if (in_rst)        o = 7'b0001010;
    else if (frz)      o = 7'b0000000;
    else if (v.br)     o = 7'b1101111;
    else if (lu || mdh) o = 7'b0110111;
    else if (v.jmp)    o = 7'b1101101;
    else               o = 7'b1100101;
    return {o, (m_md_rem > 0), m_hold};
  endfunction

  task automatic model_posedge(in_t v);
    if (v.rst) begin
      m_rst_q = 1'b1;
    end else if (m_rst_q) begin
      m_rst_q = 1'b0;
    end else begin
      m_hold = !v.rdy;
      if (v.mds && v.rdy) m_md_rem = MD_LAT;
      else if (m_md_rem > 0) m_md_rem--;
    end
  endtask

  vec_t tbl[12];
  in_t  idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 7'b1100101, "idle"};
    tbl[1]  = '{mk(8, 0, 1, 0, 0, 0, 1, 8, 0, 0, 1), 7'b0110111, "lu_rs"};
    tbl[2]  = '{mk(0, 5, 0, 1, 0, 0, 1, 5, 0, 0, 1), 7'b0110111, "lu_rt"};
    tbl[3]  = '{mk(0, 5, 0, 0, 0, 0, 1, 5, 0, 0, 1), 7'b1100101, "rt_unused"};
    tbl[4]  = '{mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1), 7'b1100101, "x0"};
    tbl[5]  = '{mk(8, 0, 1, 0, 0, 0, 0, 8, 0, 0, 1), 7'b1100101, "no_load"};
    tbl[6]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), 7'b1101101, "jump"};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), 7'b1101111, "branch"};
    tbl[8]  = '{mk(8, 0, 1, 0, 0, 0, 1, 8, 1, 0, 1), 7'b1101111, "br_beats_lu"};
    tbl[9]  = '{mk(8, 0, 1, 0, 0, 1, 1, 8, 0, 0, 1), 7'b0110111, "lu_beats_jump"};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 7'b0000000, "freeze_br"};
    tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 7'b1100101, "unfreeze"};

    set_in(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {2'b00, w_out7}, {2'b00, 7'b0001010});
    chk("reset_state", {7'b0, md_busy, mem_hold}, 9'b0);
    rst = 1'b0;
    adv();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].in);
      @(negedge clk);
      chk(tbl[i].name, {2'b00, w_out7}, {2'b00, tbl[i].exp});
      adv();
    end

    // Load-use lasts one cycle once the bubble clears ex_memread
    set_in(mk(8, 0, 1, 0, 0, 0, 1, 8, 0, 0, 1));
    @(negedge clk);
    chk("lu_seq_stall", {2'b00, w_out7}, {2'b00, 7'b0110111});
    adv();
    set_in(mk(8, 0, 1, 0, 0, 0, 0, 8, 0, 0, 1));
    @(negedge clk);
    chk("lu_seq_next", {2'b00, w_out7}, {2'b00, 7'b1100101});
    adv();

    // Memory freeze with a pending branch
    for (int k = 0; k < 3; k++) begin
      set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      @(negedge clk);
      chk("frz_ctrl", {2'b00, w_out7}, 9'b0);
      chk("frz_hold", {8'b0, mem_hold}, {8'b0, (k > 0)});
      adv();
    end
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    @(negedge clk);
    chk("frz_release", {7'b0, ifid_flush, idex_flush}, 9'b11);
    adv();
    set_in(idle);
    adv();

    // Mult/div occupancy
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    @(negedge clk);
    chk("md_issue", {8'b0, pc_write}, 9'd1);
    adv();
    for (int k = 0; k < MD_LAT; k++) begin
      set_in(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
      chk("md_stall", {6'b0, md_busy, pc_write, ifid_stall}, 9'b101);
      adv();
    end
    @(negedge clk);
    chk("md_done", {7'b0, md_busy, pc_write}, 9'b01);
    adv();

    // Reset in the middle of a countdown
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    adv();
    set_in(idle);
    adv();
    adv();
    @(negedge clk);
    chk("md_pre_rst", {8'b0, md_busy}, 9'd1);
    rst = 1'b1;
    #1;
    chk("md_rst_busy", {8'b0, md_busy}, 9'd0);
    chk("md_rst_ctrl", {2'b00, w_out7}, {2'b00, 7'b0001010});
    adv();
    rst = 1'b0;
    #1;
    chk("rst_release_hold", {8'b0, pc_write}, 9'd0);
    adv();
    set_in(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    chk("post_rst_md", {7'b0, pc_write, ifid_stall}, 9'b10);
    adv();

    // Randomized run against the reference model
    for (int i = 0; i < 1500; i++) begin
      in_t v;
      logic [8:0] e;
      v.rs  = 5'($urandom_range(0, 3));
      v.rt  = 5'($urandom_range(0, 3));
      v.rd  = 5'($urandom_range(0, 3));
      v.urs = 1'($urandom_range(0, 1));
      v.urt = 1'($urandom_range(0, 1));
      v.mdu = 1'($urandom_range(0, 1));
      v.mr  = 1'($urandom_range(0, 1));
      v.jmp = ($urandom_range(0, 5) == 0);
      v.br  = ($urandom_range(0, 5) == 0);
      v.mds = ($urandom_range(0, 7) == 0);
      v.rdy = ($urandom_range(0, 4) != 0);
      v.rst = (i < 2) || ($urandom_range(0, 99) == 0);
      set_in(v);
      if (v.rst) begin
        m_md_rem = 0;
        m_hold   = 1'b0;
        m_rst_q  = 1'b1;
      end
      @(negedge clk);
      exp_q.push_back(model_out(v));
      e = exp_q.pop_front();
      chk("rand", {w_out7, md_busy, mem_hold}, e);
      @(posedge clk);
      model_posedge(v);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
